// File: rtl/ethpipe_tx_framer.sv
// GMII transmit framer: fetches one slot (header + payload), waits for its launch time, emits
// preamble/SFD, payload and optional FCS (ETHPIPE_TX_CRC_EN), enforces IFG, then pulses tx_done.
module ethpipe_tx_framer #(
  parameter int IFG_CYCLES    = 12,
  parameter int MAX_FRAME_LEN = 1514,
  parameter int READY_HOLDOFF = 4
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst,
  input  logic [63:0] global_counter,
  input  logic        tx_ready,
  output logic [10:0] slot_tx_eth_address,
  output logic        slot_tx_eth_rd_en,
  input  logic [31:0] slot_tx_eth_q,
  output logic        tx_done,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {IDLE, HDR, WAIT, PRE, DATA, FCS, GAP, DONE} state_t;

  localparam int          HOLD_W   = (READY_HOLDOFF < 2) ? 1 : $clog2(READY_HOLDOFF + 1);
  localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME_LEN);
  localparam logic [10:0] IFG_LAST = 11'(IFG_CYCLES - 1);

  state_t              state_q, state_d;
  logic [10:0]         cnt_q, cnt_d, cnt_inc;
  logic [10:0]         len_q, len_raw, len_clamped;
  logic [63:0]         launch_q;
  logic [31:0]         cur_word_q, nxt_word_q, src_word;
  logic                rd_pend_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [7:0]          txd_q, txd_d, data_byte;
  logic                tx_en_q, en_d, done_q, done_d;
  logic                rd_en;
  logic [10:0]         addr;
  logic [1:0]          lane_inc;

  // Handshake: slot_tx_eth_rd_en is a one-cycle strobe; slot_tx_eth_q is taken the cycle after.
  assign slot_tx_eth_rd_en   = rd_en;
  assign slot_tx_eth_address = addr;
  assign gmii_txd            = txd_q;
  assign gmii_tx_en          = tx_en_q;
  assign tx_done             = done_q;
  assign dbg_state           = state_q;

  assign cnt_inc     = cnt_q + 11'd1;
  assign lane_inc    = cnt_inc[1:0];
  assign src_word    = (lane_inc == 2'd0) ? nxt_word_q : cur_word_q;
  assign data_byte   = src_word[{lane_inc, 3'b000} +: 8];
  assign len_raw     = slot_tx_eth_q[26:16];
  assign len_clamped = (len_raw > MAX_LEN) ? MAX_LEN : len_raw;

`ifdef ETHPIPE_TX_CRC_EN
  logic [31:0] crc_q, fcs_word;
  logic [7:0]  fcs_byte;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  assign fcs_word = ~crc_q;
  assign fcs_byte = fcs_word[{lane_inc, 3'b000} +: 8];
`endif

  // Output registers are loaded with the byte belonging to the state being entered,
  // so gmii_* line up with state_q without an extra pipeline stage.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    txd_d   = 8'h00;
    en_d    = 1'b0;
    done_d  = 1'b0;
    rd_en   = 1'b0;
    addr    = 11'd0;
    case (state_q)
      IDLE: begin
        if (tx_ready && hold_q == '0) begin
          state_d = HDR;
          cnt_d   = 11'd0;
        end
      end
      HDR: begin
        if (cnt_q < 11'd4) begin
          rd_en = 1'b1;
          addr  = cnt_q;
          cnt_d = cnt_inc;
        end else begin
          cnt_d = 11'd0;
          if (len_clamped == 11'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (global_counter >= launch_q) begin
          state_d = PRE;
          cnt_d   = 11'd0;
          en_d    = 1'b1;
          txd_d   = 8'h55;
        end
      end
      PRE: begin
        en_d = 1'b1;
        if (cnt_q == 11'd0) begin
          rd_en = 1'b1;
          addr  = 11'd4;
        end
        if (cnt_q == 11'd7) begin
          state_d = DATA;
          cnt_d   = 11'd0;
          txd_d   = nxt_word_q[7:0];
        end else begin
          cnt_d = cnt_inc;
          txd_d = (cnt_q == 11'd6) ? 8'hD5 : 8'h55;
        end
      end
      DATA: begin
        // Prefetch the following word while the first lane of this one is on the wire.
        if (cnt_q[1:0] == 2'd0 && (cnt_q + 11'd4) < len_q) begin
          rd_en = 1'b1;
          addr  = 11'd5 + (cnt_q >> 2);
        end
        if (cnt_q == len_q - 11'd1) begin
          cnt_d = 11'd0;
`ifdef ETHPIPE_TX_CRC_EN
          state_d = FCS;
          en_d    = 1'b1;
          txd_d   = fcs_word[7:0];
`else
          state_d = GAP;
`endif
        end else begin
          cnt_d = cnt_inc;
          en_d  = 1'b1;
          txd_d = data_byte;
        end
      end
      FCS: begin
        if (cnt_q == 11'd3) begin
          state_d = GAP;
          cnt_d   = 11'd0;
        end else begin
          cnt_d = cnt_inc;
          en_d  = 1'b1;
`ifdef ETHPIPE_TX_CRC_EN
          txd_d = fcs_byte;
`endif
        end
      end
      GAP: begin
        if (cnt_q == IFG_LAST) begin
          state_d = DONE;
          cnt_d   = 11'd0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      launch_q   <= '0;
      cur_word_q <= '0;
      nxt_word_q <= '0;
      rd_pend_q  <= 1'b0;
      hold_q     <= '0;
      txd_q      <= '0;
      tx_en_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      txd_q     <= txd_d;
      tx_en_q   <= en_d;
      done_q    <= done_d;
      rd_pend_q <= rd_en;
      if (state_q == DONE) hold_q <= HOLD_W'(READY_HOLDOFF);
      else if (hold_q != '0) hold_q <= hold_q - 1'b1;
      if (state_q == HDR) begin
        case (cnt_q)
          11'd1:   launch_q[31:0]  <= slot_tx_eth_q;
          11'd2:   launch_q[63:32] <= slot_tx_eth_q;
          11'd4:   len_q           <= len_clamped;
          default: ;
        endcase
      end
      if (rd_pend_q) nxt_word_q <= slot_tx_eth_q;
      if (state_d == DATA && cnt_d[1:0] == 2'd0) cur_word_q <= nxt_word_q;
    end
  end

`ifdef ETHPIPE_TX_CRC_EN
  always_ff @(posedge gmii_tx_clk) begin
    if (sys_rst) crc_q <= 32'hFFFFFFFF;
    else if (state_q == WAIT) crc_q <= 32'hFFFFFFFF;
    else if (en_d && state_d == DATA) crc_q <= crc32_byte(crc_q, txd_d);
  end
`endif

endmodule
